ch_bram_loader: RTL and testbench
=================================

CH_BRAM_LOADER -- requirements
Module: ch_bram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, BRAM port-B word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM port-B and stream word width.
REQ-003 SHALL have port s_axi_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port s_axi_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_gpio_load_start, input, 1, GPIO level; a rising edge starts a load.
REQ-006 SHALL have port i_gpio_base_addr, input, ADDR_WIDTH, first BRAM word address, sampled at start.
REQ-007 SHALL have port i_gpio_word_count, input, ADDR_WIDTH+1, number of words to load, sampled at start.
REQ-008 SHALL have ports s_axis_tdata (input, DATA_WIDTH), s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1), the AXI-Stream slave word source.
REQ-009 SHALL have ports enb, web, addrb and dinb (outputs; widths 1, 1, ADDR_WIDTH, DATA_WIDTH), driving ch_unit BRAM port B.
REQ-010 SHALL have ports o_gpio_load_busy and o_gpio_load_done (outputs, 1 each), status flags.
REQ-011 SHALL have port o_gpio_load_err, output, 1, set when tlast arrives before the word count is reached.
REQ-012 SHALL have port o_gpio_words_written, output, ADDR_WIDTH+1, count of words written in the current or last load.
REQ-013 SHALL have port o_gpio_checksum, output, DATA_WIDTH, sum mod 2^DATA_WIDTH of the words written.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD and DONE.
REQ-015 SHALL register i_gpio_load_start once and detect a rising edge as (current & ~previous); the start takes effect on the edge after detection.
REQ-016 SHALL, on start from IDLE or DONE with word_count > 0: latch base and count; clear words_written, checksum, done and err; enter LOAD.
REQ-017 SHALL, on start with word_count == 0: enter DONE directly, with no write pulses and err = 0.
REQ-018 SHALL ignore start edges while in LOAD.
REQ-019 SHALL drive s_axis_tready = 1 exactly while state == LOAD; a beat is accepted on an edge where tvalid & tready.
REQ-020 SHALL, for a beat accepted at edge k, assert enb = web = 1 during cycle k+1 for exactly one cycle, with addrb = the current address and dinb = tdata; otherwise enb = web = 0 and addrb = dinb = 0.
REQ-021 SHALL use a current address that starts at base and increments by 1 per accepted beat, wrapping 2^ADDR_WIDTH-1 -> 0.
REQ-022 SHALL, on each accepted beat, increment words_written by 1 and add tdata to the checksum (modulo 2^DATA_WIDTH), both visible from cycle k+1.
REQ-023 SHALL, when the accepted beat is word number count, move LOAD -> DONE; tlast on that beat is ignored.
REQ-024 SHALL, when tlast is accepted before word number count, write that beat, set err = 1 and move LOAD -> DONE.
REQ-025 SHALL drive o_gpio_load_busy = 1 iff state == LOAD.
REQ-026 SHALL drive o_gpio_load_done as a register that is 1 from the cycle after the final write pulse until the next accepted start.
REQ-027 SHALL sustain a throughput of one word per clock when tvalid is held high.

Reset
REQ-028 SHALL, with s_axi_reset low, asynchronously force state = IDLE, tready = 0, enb = web = 0, addrb = dinb = 0, busy = done = err = 0, words_written = 0, checksum = 0 and the start-edge register = 0.
REQ-029 SHALL, on reset asserted mid-LOAD, drop any pending write pulse; after release the block waits in IDLE for a new rising start edge, even if i_gpio_load_start is already high.

Structure
REQ-030 SHALL take the state enum and the default ADDR_WIDTH/DATA_WIDTH constants from shared package ch_pkg.
REQ-031 SHALL implement the start edge detector as sub-module gpio_edge_det, which ch_unit's GPIO controls may reuse.

Verification
REQ-032 SHALL cover: base=0, count=4, tvalid held high, data 1,2,3,4 -> four consecutive write pulses at addresses 0..3, checksum=10, words_written=4, done=1, err=0.
REQ-033 SHALL cover: base=0x7FFE, count=4 -> addrb sequence 7FFE, 7FFF, 0000, 0001.
REQ-034 SHALL cover: count=8 with tlast on beat 3 -> 3 write pulses, err=1, done=1, words_written=3.
REQ-035 SHALL cover: tvalid toggled 1,0,1,0 during LOAD -> write pulses occur only after accepted beats, and a second start edge mid-LOAD has no effect.
REQ-036 SHALL cover: reset asserted after 2 of 6 words with start still high -> all outputs at reset values, no further writes, and IDLE held until start falls and rises again.
REQ-037 SHALL cover: count=0 -> done=1 with zero write pulses; and full load of count=32768 with $urandom data -> BRAM readback through ch_unit port B matches every word.

Source files
------------

// File: rtl/ch_pkg.sv
// Shared constants for the ch_unit blocks: default bus widths and loader FSM states.
package ch_pkg;

   localparam int unsigned CH_ADDR_WIDTH = 15;
   localparam int unsigned CH_DATA_WIDTH = 32;

   localparam int unsigned CH_STATE_W = 2;

   localparam logic [CH_STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [CH_STATE_W-1:0] ST_LOAD = 2'd1;
   localparam logic [CH_STATE_W-1:0] ST_DONE = 2'd2;

endpackage : ch_pkg

// File: rtl/gpio_edge_det.sv
// Rising-edge detector for a GPIO level. The edge is only reported once the
// level has been seen low after reset, so a level that is already high when
// reset releases is not mistaken for a new edge.
module gpio_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise_c
);

   logic r_prev;
   logic r_armed;

   // Track the previous level and arm once a low level has been observed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_prev  <= i_level;
         r_armed <= r_armed | ~i_level;
      end
   end

   // Combinational edge pulse, acted on at the following clock edge
   always_comb begin
      o_rise_c = i_level & ~r_prev & r_armed;
   end

endmodule : gpio_edge_det

// File: rtl/ch_bram_loader.sv
// Streams AXI-Stream words into ch_unit BRAM port B starting at a GPIO-supplied
// base address, tracking word count, checksum and an early-tlast error flag.
module ch_bram_loader
   import ch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CH_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = CH_DATA_WIDTH
) (
   input  logic                  s_axi_clk,
   input  logic                  s_axi_reset,
   input  logic                  i_gpio_load_start,
   input  logic [ADDR_WIDTH-1:0] i_gpio_base_addr,
   input  logic [ADDR_WIDTH:0]   i_gpio_word_count,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  enb,
   output logic                  web,
   output logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] dinb,
   output logic                  o_gpio_load_busy,
   output logic                  o_gpio_load_done,
   output logic                  o_gpio_load_err,
   output logic [ADDR_WIDTH:0]   o_gpio_words_written,
   output logic [DATA_WIDTH-1:0] o_gpio_checksum
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   logic [CH_STATE_W-1:0] r_state;
   logic [CH_STATE_W-1:0] w_state_nxt;

   logic                  r_tready;
   logic                  r_enb;
   logic                  r_web;
   logic [ADDR_WIDTH-1:0] r_addrb;
   logic [DATA_WIDTH-1:0] r_dinb;
   logic                  r_done;
   logic                  r_err;
   logic [CW-1:0]         r_words;
   logic [DATA_WIDTH-1:0] r_cks;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CW-1:0]         r_count;

   logic                  w_start_rise;
   logic                  w_start_ok;
   logic                  w_cnt_zero;
   logic                  w_accept;
   logic [CW-1:0]         w_words_inc;
   logic                  w_last_word;

   gpio_edge_det u_start_edge (
      .clk      (s_axi_clk),
      .rst_n    (s_axi_reset),
      .i_level  (i_gpio_load_start),
      .o_rise_c (w_start_rise)
   );

   // Decode start acceptance, beat acceptance and final-word condition
   always_comb begin
      w_start_ok  = w_start_rise & (r_state != ST_LOAD);
      w_cnt_zero  = (i_gpio_word_count == '0);
      w_accept    = r_tready & s_axis_tvalid;
      w_words_inc = r_words + CW'(1);
      w_last_word = (w_words_inc == r_count);
   end

   // State register
   always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
      if (!s_axi_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_ok) begin
               w_state_nxt = w_cnt_zero ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_accept && (w_last_word || s_axis_tlast)) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Load bookkeeping: address, counters, checksum and status flags
   always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
      if (!s_axi_reset) begin
         r_addr  <= '0;
         r_count <= '0;
         r_words <= '0;
         r_cks   <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_start_ok) begin
         r_addr  <= i_gpio_base_addr;
         r_count <= i_gpio_word_count;
         r_words <= '0;
         r_cks   <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= r_addr + ADDR_WIDTH'(1);
         r_words <= w_words_inc;
         r_cks   <= r_cks + s_axis_tdata;
         if (s_axis_tlast && !w_last_word) begin
            r_err <= 1'b1;
         end
      end else if (r_state == ST_DONE) begin
         r_done <= 1'b1;
      end
   end

   // BRAM write pulse one cycle after each accepted beat; ready tracks LOAD
   always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
      if (!s_axi_reset) begin
         r_tready <= 1'b0;
         r_enb    <= 1'b0;
         r_web    <= 1'b0;
         r_addrb  <= '0;
         r_dinb   <= '0;
      end else begin
         r_tready <= (w_state_nxt == ST_LOAD);
         r_enb    <= w_accept;
         r_web    <= w_accept;
         r_addrb  <= w_accept ? r_addr : '0;
         r_dinb   <= w_accept ? s_axis_tdata : '0;
      end
   end

   // Output drive
   always_comb begin
      s_axis_tready        = r_tready;
      o_gpio_load_busy     = r_tready;
      enb                  = r_enb;
      web                  = r_web;
      addrb                = r_addrb;
      dinb                 = r_dinb;
      o_gpio_load_done     = r_done;
      o_gpio_load_err      = r_err;
      o_gpio_words_written = r_words;
      o_gpio_checksum      = r_cks;
   end

endmodule : ch_bram_loader

// File: tb/tb_ch_bram_loader.sv
// Testbench for ch_bram_loader: write expectations queued by the stimulus,
// popped and compared by a negedge monitor on every BRAM write pulse.
module tb_ch_bram_loader;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   count;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;
   logic          enb;
   logic          web;
   logic [AW-1:0] addrb;
   logic [DW-1:0] dinb;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   words;
   logic [DW-1:0] cks;

   int  n_pass;
   int  n_tot;
   int  n_pulse;
   int  cyc_n;
   wr_t sb[$];
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];

   ch_bram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .s_axi_clk            (clk),
      .s_axi_reset          (rst_n),
      .i_gpio_load_start    (start),
      .i_gpio_base_addr     (base),
      .i_gpio_word_count    (count),
      .s_axis_tdata         (tdata),
      .s_axis_tvalid        (tvalid),
      .s_axis_tlast         (tlast),
      .s_axis_tready        (tready),
      .enb                  (enb),
      .web                  (web),
      .addrb                (addrb),
      .dinb                 (dinb),
      .o_gpio_load_busy     (busy),
      .o_gpio_load_done     (done),
      .o_gpio_load_err      (err),
      .o_gpio_words_written (words),
      .o_gpio_checksum      (cks)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Monitor: every write pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (enb) begin
         n_pulse++;
         if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_write addrb=%0h dinb=%0h required=no pulse", addrb, dinb);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 64'(addrb), 64'(e.a));
            chk("wr_data", 64'(dinb), 64'(e.d));
            chk("wr_web", 64'(web), 64'd1);
         end
         if (web) mem[addrb] = dinb;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] c, input bit keep_high);
      base  = b;
      count = c;
      start = 1'b1;
      cyc();
      if (!keep_high) start = 1'b0;
   endtask

   // Present one beat, wait (bounded) for ready, queue its expected write
   task automatic send_beat(input logic [DW-1:0] d, input logic last,
                            input logic [AW-1:0] a, input bit exp_pulse);
      int w;
      w      = 0;
      tvalid = 1'b1;
      tdata  = d;
      tlast  = last;
      while (!tready && w < 50) begin
         cyc();
         w++;
      end
      if (!tready) chk("beat_ready_timeout", 64'(tready), 64'd1);
      else if (exp_pulse) sb.push_back('{a: a, d: d});
      cyc();
      tlast = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tready"}, 64'(tready), 64'd0);
      chk({tag, "_enb"},    64'(enb),    64'd0);
      chk({tag, "_web"},    64'(web),    64'd0);
      chk({tag, "_addrb"},  64'(addrb),  64'd0);
      chk({tag, "_dinb"},   64'(dinb),   64'd0);
      chk({tag, "_busy"},   64'(busy),   64'd0);
      chk({tag, "_done"},   64'(done),   64'd0);
      chk({tag, "_err"},    64'(err),    64'd0);
      chk({tag, "_words"},  64'(words),  64'd0);
      chk({tag, "_cks"},    64'(cks),    64'd0);
   endtask

   task automatic chk_status(input string tag, input logic b, input logic dn, input logic er,
                             input logic [AW:0] wc, input logic [DW-1:0] cs);
      chk({tag, "_busy"},  64'(busy),  64'(b));
      chk({tag, "_done"},  64'(done),  64'(dn));
      chk({tag, "_err"},   64'(err),   64'(er));
      chk({tag, "_words"}, 64'(words), 64'(wc));
      chk({tag, "_cks"},   64'(cks),   64'(cs));
   endtask

   initial begin
      int t0;
      int p0;
      logic [DW-1:0] d;
      logic [DW-1:0] sum;
      n_pass = 0; n_tot = 0; n_pulse = 0; cyc_n = 0;
      rst_n = 1'b0; start = 1'b0; base = '0; count = '0;
      tdata = '0; tvalid = 1'b0; tlast = 1'b0;
      #12;
      chk_reset_vals("rst");
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();

      // Base 0, count 4, data 1..4 back to back; tlast on the final beat is ignored
      start_load(15'h0000, 16'd4, 1'b0);
      chk("t1_busy_start", 64'(busy), 64'd1);
      chk("t1_tready", 64'(tready), 64'd1);
      t0 = cyc_n;
      for (int i = 0; i < 4; i++) send_beat(32'(i + 1), (i == 3), 15'(i), 1'b1);
      chk("t1_throughput_cycles", 64'(cyc_n - t0), 64'd4);
      tvalid = 1'b0;
      chk("t1_tready_after", 64'(tready), 64'd0);
      cyc();
      chk_status("t1", 1'b0, 1'b1, 1'b0, 16'd4, 32'd10);

      // Address wrap from 7FFE through 0001, restarted from DONE
      start_load(15'h7FFE, 16'd4, 1'b0);
      chk("t2_done_cleared", 64'(done), 64'd0);
      send_beat(32'h11, 1'b0, 15'h7FFE, 1'b1);
      send_beat(32'h22, 1'b0, 15'h7FFF, 1'b1);
      send_beat(32'h33, 1'b0, 15'h0000, 1'b1);
      send_beat(32'h44, 1'b0, 15'h0001, 1'b1);
      tvalid = 1'b0;
      cyc(); cyc();
      chk_status("t2", 1'b0, 1'b1, 1'b0, 16'd4, 32'hAA);

      // Early tlast on beat 3 of 8
      start_load(15'h0100, 16'd8, 1'b0);
      send_beat(32'h5, 1'b0, 15'h0100, 1'b1);
      send_beat(32'h6, 1'b0, 15'h0101, 1'b1);
      send_beat(32'h7, 1'b1, 15'h0102, 1'b1);
      tvalid = 1'b0;
      chk("t3_err_early", 64'(err), 64'd1);
      cyc(); cyc();
      chk_status("t3", 1'b0, 1'b1, 1'b1, 16'd3, 32'd18);

      // Gapped tvalid plus an ignored start edge mid-load
      start_load(15'h0020, 16'd4, 1'b0);
      send_beat(32'hA0, 1'b0, 15'h0020, 1'b1);
      tvalid = 1'b0;
      base = 15'h0500; count = 16'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      chk("t4_busy_after_edge", 64'(busy), 64'd1);
      send_beat(32'hA1, 1'b0, 15'h0021, 1'b1);
      tvalid = 1'b0; cyc();
      send_beat(32'hA2, 1'b0, 15'h0022, 1'b1);
      tvalid = 1'b0; cyc();
      send_beat(32'hA3, 1'b0, 15'h0023, 1'b1);
      tvalid = 1'b0;
      cyc(); cyc();
      chk_status("t4", 1'b0, 1'b1, 1'b0, 16'd4, 32'h286);

      // Reset after 2 of 6 words with start held high; pending pulse must vanish
      start_load(15'h0040, 16'd6, 1'b1);
      send_beat(32'hB0, 1'b0, 15'h0040, 1'b1);
      send_beat(32'hB1, 1'b0, 15'h0041, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("t5_rst");
      cyc(); cyc();
      rst_n = 1'b1;
      p0 = n_pulse;
      repeat (8) cyc();
      chk("t5_no_writes", 64'(n_pulse - p0), 64'd0);
      chk_status("t5_idle", 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      chk("t5_tready", 64'(tready), 64'd0);
      tvalid = 1'b0; start = 1'b0;
      cyc(); cyc();
      start_load(15'h0060, 16'd2, 1'b0);
      send_beat(32'hC0, 1'b0, 15'h0060, 1'b1);
      send_beat(32'hC1, 1'b0, 15'h0061, 1'b1);
      tvalid = 1'b0;
      cyc(); cyc();
      chk_status("t5_reload", 1'b0, 1'b1, 1'b0, 16'd2, 32'h181);

      // Zero-length load goes straight to DONE with no writes
      p0 = n_pulse;
      tvalid = 1'b1; tdata = 32'hDEAD;
      start_load(15'h0010, 16'd0, 1'b0);
      chk("t6_tready", 64'(tready), 64'd0);
      cyc(); cyc();
      tvalid = 1'b0;
      chk("t6_no_writes", 64'(n_pulse - p0), 64'd0);
      chk("t6_done", 64'(done), 64'd1);
      chk("t6_err", 64'(err), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);

      // Full 32768-word load with random data, then BRAM readback
      sum = '0;
      start_load(15'h0000, 16'h8000, 1'b0);
      for (int i = 0; i < (1 << AW); i++) begin
         d = $urandom;
         exp_mem[i] = d;
         sum = sum + d;
         send_beat(d, 1'b0, 15'(i), 1'b1);
      end
      tvalid = 1'b0;
      cyc(); cyc();
      chk_status("t7", 1'b0, 1'b1, 1'b0, 16'h8000, sum);
      for (int i = 0; i < (1 << AW); i++) chk("t7_readback", 64'(mem[i]), 64'(exp_mem[i]));

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   // Global watchdog
   initial begin
      #5ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule : tb_ch_bram_loader
